// File: rtl/alarm_time_keeper_if.sv
// Front-panel bundle of the alarm clock: switch/button levels in, BCD digits,
// second tick and ring indication out.
interface alarm_time_keeper_if;
  logic       set_mode;
  logic       inc_hour;
  logic       inc_min;
  logic       alarm_en;
  logic       snooze;
  logic [3:0] hour_tens;
  logic [3:0] hour_ones;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic       sec_tick;
  logic       alarm_ring;

  modport master (
    output set_mode, inc_hour, inc_min, alarm_en, snooze,
    input  hour_tens, hour_ones, min_tens, min_ones, sec_tick, alarm_ring
  );

  modport slave (
    input  set_mode, inc_hour, inc_min, alarm_en, snooze,
    output hour_tens, hour_ones, min_tens, min_ones, sec_tick, alarm_ring
  );
endinterface

// File: rtl/alarm_time_keeper.sv
// Alarm clock core: 24-hour BCD timekeeping off a one-second prescaler,
// button-driven time/alarm setting and an IDLE/RING/SNOOZE ring controller.
module alarm_time_keeper #(
  parameter int CLKS_PER_SEC = 50000000
) (
  input logic                clk,
  input logic                rst,
  alarm_time_keeper_if.slave bus
);

  localparam int              PW          = $clog2(CLKS_PER_SEC);
  localparam logic [PW-1:0]   PRE_LAST    = PW'(CLKS_PER_SEC - 1);
  localparam logic [5:0]      RING_LAST   = 6'd59;
  localparam logic [8:0]      SNOOZE_LOAD = 9'd300;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } ringState_t;

  // BCD increment helpers; out-of-range inputs fall back to 00 so digits stay legal
  function automatic logic [7:0] incMod60(input logic [7:0] bcd);
    logic [3:0] t;
    logic [3:0] o;
    t = bcd[7:4];
    o = bcd[3:0];
    if (t > 4'd5 || o > 4'd9) return 8'h00;
    if (o < 4'd9) return {t, o + 4'd1};
    if (t < 4'd5) return {t + 4'd1, 4'd0};
    return 8'h00;
  endfunction

  function automatic logic [7:0] incMod24(input logic [7:0] bcd);
    logic [3:0] t;
    logic [3:0] o;
    t = bcd[7:4];
    o = bcd[3:0];
    if (t >= 4'd2 && o >= 4'd3) return 8'h00;
    if (t > 4'd2 || o > 4'd9) return 8'h00;
    if (o < 4'd9) return {t, o + 4'd1};
    return {t + 4'd1, 4'd0};
  endfunction

  logic [PW-1:0] r_prescale;
  logic [7:0]    r_hour;
  logic [7:0]    r_min;
  logic [7:0]    r_sec;
  logic [7:0]    r_almHour;
  logic [7:0]    r_almMin;
  logic          r_prevIncHour;
  logic          r_prevIncMin;
  logic          r_prevSnooze;
  ringState_t    r_state;
  logic [5:0]    r_ringCnt;
  logic [8:0]    r_snoozeCnt;
  logic [15:0]   r_disp;

  logic          w_tick;
  logic          w_incHourEdge;
  logic          w_incMinEdge;
  logic          w_snoozeEdge;
  logic          w_manHour;
  logic          w_manMin;
  logic          w_almHourInc;
  logic          w_almMinInc;
  logic          w_secWrap;
  logic          w_minWrap;
  logic          w_alarmHit;
  logic [PW-1:0] w_nextPre;
  logic [7:0]    w_nextSec;
  logic [7:0]    w_nextMin;
  logic [7:0]    w_nextHour;
  logic [7:0]    w_nextAlmHour;
  logic [7:0]    w_nextAlmMin;
  ringState_t    w_nextState;
  logic [5:0]    w_nextRingCnt;
  logic [8:0]    w_nextSnoozeCnt;
  logic          w_ring;

  assign w_tick        = (r_prescale == PRE_LAST);
  assign w_incHourEdge = bus.inc_hour & ~r_prevIncHour;
  assign w_incMinEdge  = bus.inc_min & ~r_prevIncMin;
  assign w_snoozeEdge  = bus.snooze & ~r_prevSnooze;
  assign w_manHour     = w_incHourEdge & ~bus.set_mode;
  assign w_manMin      = w_incMinEdge & ~bus.set_mode;
  assign w_almHourInc  = w_incHourEdge & bus.set_mode;
  assign w_almMinInc   = w_incMinEdge & bus.set_mode;
  assign w_secWrap     = w_tick && (r_sec == 8'h59);
  assign w_minWrap     = w_secWrap && (r_min == 8'h59);

  // A manual minute press and a natural carry merge into a single +1 step
  always_comb begin
    w_nextPre     = w_tick ? '0 : r_prescale + PW'(1);
    w_nextSec     = r_sec;
    w_nextMin     = r_min;
    w_nextHour    = r_hour;
    w_nextAlmHour = r_almHour;
    w_nextAlmMin  = r_almMin;
    if (w_manMin) begin
      w_nextSec = 8'h00;
      w_nextPre = '0;
    end else if (w_tick) begin
      w_nextSec = incMod60(r_sec);
    end
    if (w_manMin || w_secWrap) w_nextMin = incMod60(r_min);
    if (w_manHour || w_minWrap) w_nextHour = incMod24(r_hour);
    if (w_almMinInc) w_nextAlmMin = incMod60(r_almMin);
    if (w_almHourInc) w_nextAlmHour = incMod24(r_almHour);
  end

  assign w_alarmHit = w_secWrap && !w_manMin && !w_manHour &&
                      (w_nextMin == r_almMin) && (w_nextHour == r_almHour);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale    <= '0;
      r_sec         <= 8'h00;
      r_min         <= 8'h00;
      r_hour        <= 8'h00;
      r_almMin      <= 8'h00;
      r_almHour     <= 8'h06;
      r_prevIncHour <= 1'b0;
      r_prevIncMin  <= 1'b0;
      r_prevSnooze  <= 1'b0;
    end else begin
      r_prescale    <= w_nextPre;
      r_sec         <= w_nextSec;
      r_min         <= w_nextMin;
      r_hour        <= w_nextHour;
      r_almMin      <= w_nextAlmMin;
      r_almHour     <= w_nextAlmHour;
      r_prevIncHour <= bus.inc_hour;
      r_prevIncMin  <= bus.inc_min;
      r_prevSnooze  <= bus.snooze;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp <= 16'h0000;
    end else if (bus.set_mode) begin
      r_disp <= {r_almHour, r_almMin};
    end else begin
      r_disp <= {r_hour, r_min};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ringCnt   <= 6'd0;
      r_snoozeCnt <= 9'd0;
    end else begin
      r_state     <= w_nextState;
      r_ringCnt   <= w_nextRingCnt;
      r_snoozeCnt <= w_nextSnoozeCnt;
    end
  end

  // Disarming wins over every other transition, including a pending snooze
  always_comb begin
    w_nextState     = r_state;
    w_nextRingCnt   = r_ringCnt;
    w_nextSnoozeCnt = r_snoozeCnt;
    w_ring          = (r_state == RING);
    if (!bus.alarm_en) begin
      w_nextState     = IDLE;
      w_nextRingCnt   = 6'd0;
      w_nextSnoozeCnt = 9'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_alarmHit) begin
            w_nextState   = RING;
            w_nextRingCnt = 6'd0;
          end
        end
        RING: begin
          if (w_snoozeEdge) begin
            w_nextState     = SNOOZE;
            w_nextSnoozeCnt = SNOOZE_LOAD;
            w_nextRingCnt   = 6'd0;
          end else if (w_tick) begin
            if (r_ringCnt >= RING_LAST) begin
              w_nextState   = IDLE;
              w_nextRingCnt = 6'd0;
            end else begin
              w_nextRingCnt = r_ringCnt + 6'd1;
            end
          end
        end
        SNOOZE: begin
          if (w_tick) begin
            if (r_snoozeCnt <= 9'd1) begin
              w_nextState     = RING;
              w_nextRingCnt   = 6'd0;
              w_nextSnoozeCnt = 9'd0;
            end else begin
              w_nextSnoozeCnt = r_snoozeCnt - 9'd1;
            end
          end
        end
        default: begin
          w_nextState     = IDLE;
          w_nextRingCnt   = 6'd0;
          w_nextSnoozeCnt = 9'd0;
        end
      endcase
    end
  end

  assign bus.sec_tick   = w_tick & ~rst;
  assign bus.alarm_ring = w_ring & ~rst;
  assign bus.hour_tens  = r_disp[15:12];
  assign bus.hour_ones  = r_disp[11:8];
  assign bus.min_tens   = r_disp[7:4];
  assign bus.min_ones   = r_disp[3:0];

endmodule

// File: tb/tb_alarm_time_keeper.sv
// Directed bench for alarm_time_keeper at four clocks per second; expected
// digit values are written as packed BCD hex (16'hHHMM).
module tb_alarm_time_keeper;

  localparam int CPS = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   tickCount;

  alarm_time_keeper_if bus ();

  alarm_time_keeper #(.CLKS_PER_SEC(CPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic checkDigits(input string tag, input logic [15:0] expected);
    checkOutput(tag, {16'h0, bus.hour_tens, bus.hour_ones, bus.min_tens, bus.min_ones},
                {16'h0, expected});
  endtask

  task automatic applyStimulus(input logic hr, input logic mn, input logic sz);
    bus.inc_hour = hr;
    bus.inc_min  = mn;
    bus.snooze   = sz;
  endtask

  task automatic pressButtons(input logic hr, input logic mn, input logic sz, input int n);
    repeat (n) begin
      applyStimulus(hr, mn, sz);
      step(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      step(1);
    end
  endtask

  // Returns just after the edge that consumed the n-th second tick
  task automatic waitTicks(input int n);
    int seen;
    int budget;
    seen   = 0;
    budget = n * CPS * 2 + 16;
    while (seen < n && budget > 0) begin
      if (bus.sec_tick === 1'b1) seen++;
      step(1);
      budget--;
    end
    checkOutput("tick_wait", seen, n);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0);
    bus.set_mode = 1'b0;
    rst = 1'b1;
    step(1);
    checkOutput("rst_sec_tick", bus.sec_tick, 0);
    checkOutput("rst_ring", bus.alarm_ring, 0);
    checkDigits("rst_digits", 16'h0000);
    step(1);
    rst = 1'b0;
    checkDigits("post_rst_digits", 16'h0000);
    checkOutput("post_rst_sec_tick", bus.sec_tick, 0);
  endtask

  task automatic ringSetup();
    doReset();
    bus.alarm_en = 1'b1;
    bus.set_mode = 1'b1;
    step(1);
    pressButtons(1'b1, 1'b0, 1'b0, 1);
    pressButtons(1'b0, 1'b1, 1'b0, 30);
    step(1);
    checkDigits("alarm_0730", 16'h0730);
    bus.set_mode = 1'b0;
    step(2);
    checkDigits("time_untouched_by_alarm_set", 16'h0000);
    pressButtons(1'b1, 1'b0, 1'b0, 7);
    pressButtons(1'b0, 1'b1, 1'b0, 29);
    waitTicks(59);
    checkOutput("pre_alarm_idle", bus.alarm_ring, 0);
    waitTicks(1);
    checkOutput("alarm_rings", bus.alarm_ring, 1);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.set_mode = 1'b0;
    bus.alarm_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);

    // Prescaler cadence and the seconds count it produces
    doReset();
    tickCount = 0;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("tick_pattern_%0d", i), bus.sec_tick, (i % 4 == 3) ? 1 : 0);
      if (bus.sec_tick === 1'b1) tickCount++;
      step(1);
    end
    checkOutput("tick_count16", tickCount, 4);
    waitTicks(55);
    step(1);
    checkDigits("before_min_roll", 16'h0000);
    waitTicks(1);
    step(1);
    checkDigits("min_roll_at_60s", 16'h0001);

    // Midnight rollover, held button, simultaneous buttons, manual hour wrap
    doReset();
    pressButtons(1'b1, 1'b0, 1'b0, 23);
    pressButtons(1'b0, 1'b1, 1'b0, 59);
    step(1);
    checkDigits("set_2359", 16'h2359);
    waitTicks(59);
    step(1);
    checkDigits("at_235959", 16'h2359);
    waitTicks(1);
    step(1);
    checkDigits("midnight_wrap", 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);
    checkDigits("hold_min_once", 16'h0001);
    pressButtons(1'b1, 1'b1, 1'b0, 1);
    step(1);
    checkDigits("hour_and_min_same_cycle", 16'h0102);
    pressButtons(1'b1, 1'b0, 1'b0, 23);
    step(1);
    checkDigits("manual_hour_wrap", 16'h0002);

    // Ring then 60-second timeout; snooze in IDLE does nothing
    ringSetup();
    waitTicks(59);
    checkOutput("ring_after_59", bus.alarm_ring, 1);
    waitTicks(1);
    checkOutput("ring_timeout", bus.alarm_ring, 0);
    pressButtons(1'b0, 1'b0, 1'b1, 1);
    checkOutput("snooze_in_idle", bus.alarm_ring, 0);

    // Snooze countdown, ignored re-press, restarted ring timeout
    ringSetup();
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(1);
    checkOutput("snooze_silences", bus.alarm_ring, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
    waitTicks(100);
    pressButtons(1'b0, 1'b0, 1'b1, 1);
    checkOutput("snooze_repress", bus.alarm_ring, 0);
    waitTicks(199);
    checkOutput("snooze_299", bus.alarm_ring, 0);
    waitTicks(1);
    checkOutput("snooze_expired", bus.alarm_ring, 1);
    waitTicks(59);
    checkOutput("reRing_59", bus.alarm_ring, 1);
    waitTicks(1);
    checkOutput("reRing_timeout", bus.alarm_ring, 0);

    // Disarm and snooze in the same cycle: must land in IDLE, not SNOOZE
    ringSetup();
    bus.alarm_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(1);
    checkOutput("disarm_priority", bus.alarm_ring, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    bus.alarm_en = 1'b1;
    step(1);
    waitTicks(300);
    checkOutput("no_snooze_after_disarm", bus.alarm_ring, 0);

    // Reset in the middle of ringing
    ringSetup();
    rst = 1'b1;
    #1;
    checkOutput("rst_midring_ring", bus.alarm_ring, 0);
    step(1);
    checkDigits("rst_midring_digits", 16'h0000);
    rst = 1'b0;
    step(1);
    checkOutput("after_rst_ring", bus.alarm_ring, 0);
    checkDigits("after_rst_digits", 16'h0000);
    waitTicks(59);
    step(1);
    checkDigits("after_rst_59s", 16'h0000);
    waitTicks(1);
    step(1);
    checkDigits("after_rst_60s", 16'h0001);

    // Manual minute coinciding with the 12:34:59 tick, then display switch
    doReset();
    pressButtons(1'b1, 1'b0, 1'b0, 12);
    pressButtons(1'b0, 1'b1, 1'b0, 34);
    waitTicks(59);
    step(3);
    checkOutput("tick_at_coincide", bus.sec_tick, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
    checkDigits("coincide_1235", 16'h1235);
    waitTicks(59);
    step(1);
    checkDigits("coincide_secs_zero_59", 16'h1235);
    waitTicks(1);
    step(1);
    checkDigits("coincide_secs_zero_60", 16'h1236);
    bus.set_mode = 1'b1;
    #1;
    checkDigits("mode_switch_lag", 16'h1236);
    step(1);
    checkDigits("mode_switch_alarm", 16'h0600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_time_keeper.md
ALARM_TIME_KEEPER -- requirements
Module: alarm_time_keeper

Interface
REQ-001 Parameter SHALL be: CLKS_PER_SEC, default 50000000, clock cycles per one-second tick (minimum 2).
REQ-002 Port SHALL be: clk  input  1  system clock, all logic on rising edge.
REQ-003 Port SHALL be: rst  input  1  synchronous, active-high reset.
REQ-004 Port SHALL be: set_mode  input  1  0 = display/adjust current time, 1 = display/adjust alarm time.
REQ-005 Port SHALL be: inc_hour  input  1  debounced level from hour button; action on rising edge only.
REQ-006 Port SHALL be: inc_min  input  1  debounced level from minute button; action on rising edge only.
REQ-007 Port SHALL be: alarm_en  input  1  alarm arm switch, level.
REQ-008 Port SHALL be: snooze  input  1  debounced level from snooze button; action on rising edge only.
REQ-009 Port SHALL be: hour_tens, hour_ones, min_tens, min_ones  output  4 each  BCD digits feeding the seven-segment decoders.
REQ-010 Port SHALL be: sec_tick  output  1  one-cycle pulse per elapsed second.
REQ-011 Port SHALL be: alarm_ring  output  1  high while alarm sounds.

Function
REQ-012 Prescaler SHALL count 0..CLKS_PER_SEC-1 and wrap; sec_tick SHALL be high exactly in the cycle the prescaler equals CLKS_PER_SEC-1.
REQ-013 Current time SHALL be 24-hour BCD hh:mm:ss; on sec_tick seconds increment, 59->00 carries to minutes, minutes 59->00 carry to hours, 23:59:59->00:00:00.
REQ-014 Every digit SHALL stay legal at all times: hour tens 0-2, hour 00-23, minute tens 0-5, ones 0-9.
REQ-015 Button edges SHALL be detected with one registered previous-value flop per button; a held button SHALL produce exactly one action.
REQ-016 set_mode=0: inc_min edge SHALL add one minute to current time (59->00, no hour carry) and clear seconds to 00 and prescaler to 0; inc_hour edge SHALL add one hour (23->00), seconds untouched.
REQ-017 set_mode=1: inc_min/inc_hour edges SHALL adjust alarm minute/hour with the same wrap rules, current time unaffected.
REQ-018 Simultaneous inc_min edge (mode 0) and a sec_tick minute carry SHALL yield net +1 minute with seconds = 00; inc_hour edge coinciding with an hour carry SHALL yield net +1 hour.
REQ-019 Simultaneous inc_hour and inc_min edges SHALL both apply in that cycle.
REQ-020 Digit outputs SHALL be registered, showing alarm hh:mm when set_mode=1 else current hh:mm, updating one cycle after the underlying value or set_mode changes.
REQ-021 Ring FSM SHALL have states IDLE, RING, SNOOZE; alarm_ring = 1 only in RING.
REQ-022 IDLE->RING SHALL occur in the cycle after a sec_tick that makes current time equal alarm hh:mm:00, only if alarm_en=1; a manual time adjustment SHALL NOT trigger.
REQ-023 RING: snooze edge -> SNOOZE loading 300-second countdown; 60 sec_ticks without snooze -> IDLE.
REQ-024 SNOOZE: countdown decrements per sec_tick; reaching 0 -> RING with 60-second timeout restarted; snooze edges ignored.
REQ-025 alarm_en=0 SHALL force IDLE from any state next cycle, with priority over snooze and timeouts.
REQ-026 snooze edges in IDLE SHALL be ignored.

Reset
REQ-027 rst=1 SHALL set current time 00:00:00, alarm 06:00, prescaler 0, FSM IDLE, counters 0, edge flops 0.
REQ-028 During and one cycle after reset: all digits 0 (mode 0), sec_tick=0, alarm_ring=0; rst SHALL override all inputs, including mid-ring.

Verification (CLKS_PER_SEC=4)
REQ-029 Reset, run 16 cycles -> sec_tick every 4th cycle, 4 pulses, seconds = 04.
REQ-030 Set time 23:59:59 via buttons/ticks, one more tick -> digits 0,0,0,0; hold inc_min 20 cycles -> minutes +1 exactly once.
REQ-031 Alarm 07:30, time 07:29:59, alarm_en=1, tick -> alarm_ring=1 next cycle; 60 further ticks -> alarm_ring=0, FSM IDLE.
REQ-032 In RING press snooze -> alarm_ring=0; after 300 ticks -> alarm_ring=1; snooze during SNOOZE ignored.
REQ-033 In RING, snooze edge and alarm_en=0 same cycle -> IDLE, no SNOOZE; rst mid-RING -> alarm_ring=0, time 00:00:00.
REQ-034 inc_min edge coinciding with 12:34:59 tick in mode 0 -> 12:35:00; set_mode=1 -> digits show alarm one cycle later.
